onchip_mem_stream_reader: RTL

ONCHIP_MEM_STREAM_READER -- requirements
Module: onchip_mem_stream_reader

---
 rtl/onchip_mem_pkg.sv | 7 +
 rtl/mem_reader_fifo.sv | 48 ++++
 rtl/onchip_mem_stream_reader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared FSM state type and default widths for the on-chip memory stream reader.
package onchip_mem_pkg;
    localparam int ADDR_W_DEF     = 15;
    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_e;
endpackage

// File: rtl/mem_reader_fifo.sv
// mem_reader_fifo: synchronous show-ahead FIFO with occupancy count and flush.
module mem_reader_fifo #(
    parameter int DW    = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count,
    output logic          empty
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          rd_w;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rptr_q];
    assign rd_w    = rd_en && !empty;

    always_ff @(posedge clk)
        if (wr_en)
            mem_q[wptr_q] <= wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en)
                wptr_q <= wptr_q + AW'(1);
            if (rd_w)
                rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_w);
        end
endmodule

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader: streams a block of words from a latency-1 on-chip memory.
// Optional abort input is enabled by defining ONCHIP_MEM_STREAM_READER_ABORT_EN.
module onchip_mem_stream_reader
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W:0]     cmd_len,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                st_valid,
    input  logic                st_ready,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_sop,
    output logic                st_eop,
    output logic                busy,
    output logic                done
`ifdef ONCHIP_MEM_STREAM_READER_ABORT_EN
    ,
    input  logic                abort
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              first_q, alive_q, inflight_q, inf_sop_q, inf_eop_q, done_q;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic [DATA_W+1:0] rd_word;
    logic              fifo_empty, abort_w, last_w, issue_w;

`ifdef ONCHIP_MEM_STREAM_READER_ABORT_EN
    assign abort_w = abort && (state_q != ST_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Buffered words plus the word still in the memory pipe must leave room for one more.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue_w   = (state_q == ST_ISSUE) && !abort_w && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign last_w    = (remain_q == {{ADDR_W{1'b0}}, 1'b1});

    assign cmd_ready      = alive_q && (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue_w;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;
    assign st_valid       = !fifo_empty;
    assign {st_sop, st_eop, st_data} = rd_word;

    mem_reader_fifo #(.DW(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (reset_n),
        .flush  (abort_w),
        .wr_en  (inflight_q),
        .wr_data({inf_sop_q, inf_eop_q, mem_readdata}),
        .rd_en  (st_ready),
        .rd_data(rd_word),
        .count  (fifo_count),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            first_q    <= 1'b0;
            alive_q    <= 1'b0;
            inflight_q <= 1'b0;
            inf_sop_q  <= 1'b0;
            inf_eop_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            alive_q    <= 1'b1;
            done_q     <= 1'b0;
            inflight_q <= issue_w;
            if (issue_w) begin
                inf_sop_q <= first_q;
                inf_eop_q <= last_w;
                addr_q    <= addr_q + ADDR_W'(1);
                remain_q  <= remain_q - (ADDR_W+1)'(1);
                first_q   <= 1'b0;
            end
            case (state_q)
                ST_IDLE:
                    if (cmd_valid && cmd_ready) begin
                        addr_q   <= cmd_addr;
                        remain_q <= cmd_len;
                        first_q  <= 1'b1;
                        if (cmd_len == '0)
                            done_q <= 1'b1;
                        else
                            state_q <= ST_ISSUE;
                    end
                ST_ISSUE:
                    if (issue_w && last_w)
                        state_q <= ST_DRAIN;
                ST_DRAIN:
                    if (fifo_empty && !inflight_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                default:
                    state_q <= ST_IDLE;
            endcase
            if (abort_w) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
            end
        end
endmodule
